// File: rtl/mid3_of5_if.sv
// mid3_of5_if: sample-set / result bundle for the mid3_of5 rank filter.
// The min_out/max_out members exist only when MID3_OF5_EXTREMES_EN is defined.
interface mid3_of5_if #(
  parameter int unsigned WIDTH = 8
);

  // Upstream side: one sample set per cycle, qualified by in_valid.
  logic             in_valid;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic [WIDTH-1:0] data3;
  logic [WIDTH-1:0] data4;
  logic [WIDTH-1:0] data5;

  // Downstream side: no back-pressure, out_valid is a one-cycle pulse.
  logic             out_valid;
  logic [WIDTH-1:0] mid1;
  logic [WIDTH-1:0] mid2;
  logic [WIDTH-1:0] mid3;
`ifdef MID3_OF5_EXTREMES_EN
  logic [WIDTH-1:0] min_out;
  logic [WIDTH-1:0] max_out;
`endif

  // Driver of samples / consumer of results.
  modport master (
    output in_valid, data1, data2, data3, data4, data5,
    input  out_valid, mid1, mid2, mid3
`ifdef MID3_OF5_EXTREMES_EN
    , input min_out, max_out
`endif
  );

  // The filter itself.
  modport slave (
    input  in_valid, data1, data2, data3, data4, data5,
    output out_valid, mid1, mid2, mid3
`ifdef MID3_OF5_EXTREMES_EN
    , output min_out, max_out
`endif
  );

endinterface

// File: rtl/mid3_of5.sv
// mid3_of5: pipelined 5-input rank filter. Returns the 2nd, 3rd and 4th smallest
// of five unsigned samples, dropping the two extremes.
// Optional feature macro: MID3_OF5_EXTREMES_EN exposes the smallest and largest
// samples on min_out/max_out; without it they are computed and discarded.
//
// Pipeline: input register, then a 9-comparator sorting network split into three
// registered stages (3/3/3). A set captured at edge N is visible after edge N+3.
// Every data register only loads when the valid bit entering it is set, so the
// outputs hold the last result between pulses.
module mid3_of5 #(
  parameter int unsigned WIDTH = 8
) (
  input logic      clock,
  input logic      reset_n,
  mid3_of5_if.slave bus
);

  typedef logic [WIDTH-1:0] sample_t;

  // Compare-exchange: returns {smaller, larger}; ties keep order.
  function automatic logic [2*WIDTH-1:0] cmpx(input sample_t a, input sample_t b);
    return (a > b) ? {b, a} : {a, b};
  endfunction

  // Lane index 0 ends up smallest, lane 4 largest.
  sample_t in_q [5];
  logic    in_vq;

  sample_t s1_d [5];
  sample_t s1_q [5];
  logic    s1_vq;

  sample_t s2_d [5];
  sample_t s2_q [5];
  logic    s2_vq;

  sample_t s3_d [5];

  sample_t mid1_q;
  sample_t mid2_q;
  sample_t mid3_q;
  logic    out_valid_q;
`ifdef MID3_OF5_EXTREMES_EN
  sample_t min_q;
  sample_t max_q;
`endif

  // Capture the raw sample set; valid flag follows in_valid every cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in_vq <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        in_q[i] <= '0;
      end
    end else begin
      in_vq <= bus.in_valid;
      if (bus.in_valid) begin
        in_q[0] <= bus.data1;
        in_q[1] <= bus.data2;
        in_q[2] <= bus.data3;
        in_q[3] <= bus.data4;
        in_q[4] <= bus.data5;
      end
    end
  end

  // Stage 1 comparators: (0,1) (3,4) (2,4). Leaves lanes 2..4 partly ordered.
  always_comb begin
    s1_d = in_q;
    {s1_d[0], s1_d[1]} = cmpx(s1_d[0], s1_d[1]);
    {s1_d[3], s1_d[4]} = cmpx(s1_d[3], s1_d[4]);
    {s1_d[2], s1_d[4]} = cmpx(s1_d[2], s1_d[4]);
  end

  // Stage 1 register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_vq <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        s1_q[i] <= '0;
      end
    end else begin
      s1_vq <= in_vq;
      if (in_vq) begin
        s1_q <= s1_d;
      end
    end
  end

  // Stage 2 comparators: (2,3) (1,4) (0,3). Lane 4 now holds the maximum.
  always_comb begin
    s2_d = s1_q;
    {s2_d[2], s2_d[3]} = cmpx(s2_d[2], s2_d[3]);
    {s2_d[1], s2_d[4]} = cmpx(s2_d[1], s2_d[4]);
    {s2_d[0], s2_d[3]} = cmpx(s2_d[0], s2_d[3]);
  end

  // Stage 2 register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s2_vq <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        s2_q[i] <= '0;
      end
    end else begin
      s2_vq <= s1_vq;
      if (s1_vq) begin
        s2_q <= s2_d;
      end
    end
  end

  // Stage 3 comparators: (0,2) (1,3) (1,2). Result fully sorted.
  always_comb begin
    s3_d = s2_q;
    {s3_d[0], s3_d[2]} = cmpx(s3_d[0], s3_d[2]);
    {s3_d[1], s3_d[3]} = cmpx(s3_d[1], s3_d[3]);
    {s3_d[1], s3_d[2]} = cmpx(s3_d[1], s3_d[2]);
  end

  // Stage 3 / output register; extremes kept only when they are exported.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      mid1_q      <= '0;
      mid2_q      <= '0;
      mid3_q      <= '0;
`ifdef MID3_OF5_EXTREMES_EN
      min_q       <= '0;
      max_q       <= '0;
`endif
    end else begin
      out_valid_q <= s2_vq;
      if (s2_vq) begin
        mid1_q <= s3_d[1];
        mid2_q <= s3_d[2];
        mid3_q <= s3_d[3];
`ifdef MID3_OF5_EXTREMES_EN
        min_q  <= s3_d[0];
        max_q  <= s3_d[4];
`endif
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.mid1      = mid1_q;
  assign bus.mid2      = mid2_q;
  assign bus.mid3      = mid3_q;
`ifdef MID3_OF5_EXTREMES_EN
  assign bus.min_out   = min_q;
  assign bus.max_out   = max_q;
`endif

  // Ordering invariant on every published result.
  property p_ordered;
    @(posedge clock) disable iff (!reset_n)
      out_valid_q |-> (mid1_q <= mid2_q) && (mid2_q <= mid3_q);
  endproperty
  a_ordered: assert property (p_ordered);

endmodule

// File: tb/tb_mid3_of5.sv
// tb_mid3_of5: directed bench for mid3_of5 with a rank-counting reference model
// and a per-cycle compare process, plus literal expectations for the listed cases.
module tb_mid3_of5;

  localparam int unsigned W = 8;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  mid3_of5_if #(.WIDTH(W)) bus ();

  mid3_of5 #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Model state: pending results tagged with the rising edge they must appear after.
  int             ecount = 0;
  int             due_q [$];
  logic [5*W-1:0] val_q [$];
  logic [5*W-1:0] held = '0;
  int             run_len = 0;
  int             max_run = 0;
  int             pulses  = 0;

  bit [W-1:0] perms [10][5] = '{
    '{2, 1, 3, 4, 5}, '{2, 3, 1, 4, 5}, '{2, 3, 4, 1, 5}, '{2, 3, 4, 5, 1},
    '{1, 3, 2, 4, 5}, '{1, 3, 4, 2, 5}, '{1, 3, 4, 5, 2}, '{1, 2, 4, 3, 5},
    '{1, 2, 4, 5, 3}, '{1, 2, 3, 5, 4}
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sort by rank: each sample's position is how many samples precede it in order.
  function automatic logic [5*W-1:0] model_sort(input logic [5*W-1:0] p);
    logic [W-1:0]   x [5];
    logic [5*W-1:0] r;
    int             rank;
    r = '0;
    for (int i = 0; i < 5; i++) x[i] = p[i*W +: W];
    for (int i = 0; i < 5; i++) begin
      rank = 0;
      for (int j = 0; j < 5; j++) begin
        if (x[j] < x[i] || (x[j] == x[i] && j < i)) rank++;
      end
      r[rank*W +: W] = x[i];
    end
    return r;
  endfunction

  // Model: every accepted set becomes due three edges later.
  always @(posedge clock) begin
    ecount++;
    if (reset_n && bus.in_valid) begin
      due_q.push_back(ecount + 3);
      val_q.push_back(model_sort({bus.data5, bus.data4, bus.data3, bus.data2, bus.data1}));
    end
  end

  // Reset throws away everything in flight and zeroes the held result.
  always @(negedge reset_n) begin
    due_q.delete();
    val_q.delete();
    held = '0;
  end

  // Compare process: valid pulse and held/new values on every cycle.
  always @(negedge clock) begin
    logic exp_v;
    exp_v = (due_q.size() > 0) && (due_q[0] == ecount);
    if (exp_v) begin
      held = val_q[0];
      void'(due_q.pop_front());
      void'(val_q.pop_front());
    end
    check("cyc_out_valid", bus.out_valid, exp_v);
    check("cyc_mid1", bus.mid1, held[1*W +: W]);
    check("cyc_mid2", bus.mid2, held[2*W +: W]);
    check("cyc_mid3", bus.mid3, held[3*W +: W]);
`ifdef MID3_OF5_EXTREMES_EN
    check("cyc_min_out", bus.min_out, held[0 +: W]);
    check("cyc_max_out", bus.max_out, held[4*W +: W]);
`endif
    if (bus.out_valid) begin
      pulses++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
  end

  task automatic drive(input logic [W-1:0] a, b, c, d, e);
    bus.in_valid = 1'b1;
    bus.data1 = a;
    bus.data2 = b;
    bus.data3 = c;
    bus.data4 = d;
    bus.data5 = e;
  endtask

  // One set for one cycle; returns at the falling edge after the sampling edge.
  task automatic apply_one(input logic [W-1:0] a, b, c, d, e);
    @(negedge clock);
    drive(a, b, c, d, e);
    @(negedge clock);
    bus.in_valid = 1'b0;
  endtask

  // Bounded wait for the result pulse; it must come after the third further edge.
  task automatic wait_result(input string name, input logic [W-1:0] e1, e2, e3);
    int n;
    bit found;
    n = 0;
    found = 0;
    while (n < 8 && !found) begin
      @(negedge clock);
      n++;
      if (bus.out_valid) found = 1;
    end
    check({name, "_latency"}, n, 3);
    check({name, "_mid1"}, bus.mid1, e1);
    check({name, "_mid2"}, bus.mid2, e2);
    check({name, "_mid3"}, bus.mid3, e3);
  endtask

  initial begin
    int p0;
    bus.in_valid = 1'b0;
    bus.data1 = '0;
    bus.data2 = '0;
    bus.data3 = '0;
    bus.data4 = '0;
    bus.data5 = '0;

    // Reset state.
    repeat (3) @(negedge clock);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_mid1", bus.mid1, 0);
    check("rst_mid2", bus.mid2, 0);
    check("rst_mid3", bus.mid3, 0);
    #2 reset_n = 1'b1;

    // Single ordered set, then hold.
    apply_one(1, 2, 3, 4, 5);
    wait_result("seq", 2, 3, 4);
    repeat (2) @(negedge clock);
    check("hold_out_valid", bus.out_valid, 0);
    check("hold_mid1", bus.mid1, 2);
    check("hold_mid2", bus.mid2, 3);
    check("hold_mid3", bus.mid3, 4);

    // Ten back-to-back permutations.
    max_run = 0;
    p0 = pulses;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      drive(perms[k][0], perms[k][1], perms[k][2], perms[k][3], perms[k][4]);
    end
    @(negedge clock);
    bus.in_valid = 1'b0;
    repeat (6) @(negedge clock);
    check("b2b_pulses", pulses - p0, 10);
    check("b2b_run", max_run, 10);
    check("b2b_mid2", bus.mid2, 3);

    // Boundary values.
    apply_one(255, 0, 128, 255, 0);
    wait_result("bound", 0, 128, 255);
`ifdef MID3_OF5_EXTREMES_EN
    check("bound_min_out", bus.min_out, 0);
    check("bound_max_out", bus.max_out, 255);
`endif

    // Duplicates.
    apply_one(7, 7, 7, 2, 9);
    wait_result("dup", 7, 7, 7);
`ifdef MID3_OF5_EXTREMES_EN
    check("dup_min_out", bus.min_out, 2);
    check("dup_max_out", bus.max_out, 9);
`endif
    apply_one(8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h5A);
    wait_result("same", 8'h5A, 8'h5A, 8'h5A);

    // Reset with two sets in flight.
    @(negedge clock);
    drive(1, 1, 2, 3, 4);
    @(negedge clock);
    drive(10, 20, 30, 40, 50);
    @(negedge clock);
    bus.in_valid = 1'b0;
    p0 = pulses;
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_out_valid", bus.out_valid, 0);
    check("async_rst_mid1", bus.mid1, 0);
    check("async_rst_mid2", bus.mid2, 0);
    check("async_rst_mid3", bus.mid3, 0);
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b1;
    repeat (6) @(negedge clock);
    check("flushed_pulses", pulses - p0, 0);

    // First set after reset.
    apply_one(9, 8, 7, 6, 5);
    wait_result("post_rst", 6, 7, 8);

    // A few more mixed sets, checked by the model only.
    apply_one(200, 13, 13, 99, 254);
    apply_one(0, 255, 1, 254, 2);
    repeat (6) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
